smc_wr_strobe_gen: RTL and testbench

SMC_WR_STROBE_GEN -- requirements
Module: smc_wr_strobe_gen

---
 rtl/smc_wr_strobe_gen.sv | 79 +++++++
 tb/tb_smc_wr_strobe_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/smc_wr_strobe_gen.sv
// smc_wr_strobe_gen: SRAM-style write strobe sequencer (IDLE/SETUP/STROBE/HOLD).
// Define SMC_WR_BURST_EN to allow back-to-back accesses without an IDLE cycle.
module smc_wr_strobe_gen #(
  parameter int BYTE_LANES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  hclk,
  input  logic                  sys_reset,
  input  logic                  wr_req,
  input  logic [BYTE_LANES-1:0] wr_be,
  input  logic [CNT_W-1:0]      cfg_setup,
  input  logic [CNT_W-1:0]      cfg_pulse,
  input  logic [CNT_W-1:0]      cfg_hold,
  output logic                  wr_ready,
  output logic                  wr_done,
  output logic                  busy,
  output logic [BYTE_LANES-1:0] smc_n_we,
  output logic                  smc_n_wr
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, pulse_q, pulse_n, hold_q, hold_n;
  logic [BYTE_LANES-1:0] be_q, be_n;
  logic accept;
  // Strobes are registered from the next state so they line up exactly with STROBE cycles
  always_ff @(posedge hclk or posedge sys_reset)
    if (sys_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      be_q     <= '0;
      pulse_q  <= '0;
      hold_q   <= '0;
      smc_n_wr <= 1'b1;
      smc_n_we <= '1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      be_q     <= be_n;
      pulse_q  <= pulse_n;
      hold_q   <= hold_n;
      smc_n_wr <= state_n != STROBE;
      smc_n_we <= (state_n == STROBE) ? ~be_n : '1;
    end
  always_comb begin
    accept  = wr_req & wr_ready;
    be_n    = accept ? wr_be : be_q;
    pulse_n = accept ? cfg_pulse : pulse_q;
    hold_n  = accept ? cfg_hold : hold_q;
    state_n = state;
    cnt_n   = cnt;
    if (accept) begin
      state_n = (|cfg_setup) ? SETUP : STROBE;
      cnt_n   = (|cfg_setup) ? cfg_setup - CNT_W'(1) : cfg_pulse;
    end else if (state != IDLE && |cnt)
      cnt_n = cnt - CNT_W'(1);
    else
      case (state)
        SETUP: begin
          state_n = STROBE;
          cnt_n   = pulse_q;
        end
        STROBE: begin
          state_n = (|hold_q) ? HOLD : IDLE;
          cnt_n   = (|hold_q) ? hold_q - CNT_W'(1) : '0;
        end
        HOLD:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_comb begin
    busy    = state != IDLE;
    wr_done = (state == HOLD || (state == STROBE && ~|hold_q)) && ~|cnt;
`ifdef SMC_WR_BURST_EN
    wr_ready = ~busy | wr_done;
`else
    wr_ready = ~busy;
`endif
  end
endmodule

// File: tb/tb_smc_wr_strobe_gen.sv
// tb_smc_wr_strobe_gen: vector table plus cycle-level scoreboard for smc_wr_strobe_gen.
module tb_smc_wr_strobe_gen;
  logic hclk = 1'b0, sys_reset = 1'b1, wr_req = 1'b0;
  logic [3:0] wr_be = '0, cfg_setup = '0, cfg_pulse = '0, cfg_hold = '0;
  logic wr_ready, wr_done, busy, smc_n_wr;
  logic [3:0] smc_n_we;
  int total = 0, bad = 0, acc_cnt = 0;
  bit chk_en = 1'b0;
`ifdef SMC_WR_BURST_EN
  localparam bit BURST = 1'b1;
  localparam int PERIOD = 3;
`else
  localparam bit BURST = 1'b0;
  localparam int PERIOD = 4;
`endif
  typedef struct packed {logic done; logic n_wr; logic [3:0] n_we;} cyc_t;
  typedef struct {logic [3:0] setup, pulse, hold, be; int exp_busy; int exp_low;} vec_t;
  cyc_t q[$];

  smc_wr_strobe_gen dut (
    .hclk(hclk), .sys_reset(sys_reset), .wr_req(wr_req), .wr_be(wr_be),
    .cfg_setup(cfg_setup), .cfg_pulse(cfg_pulse), .cfg_hold(cfg_hold),
    .wr_ready(wr_ready), .wr_done(wr_done), .busy(busy),
    .smc_n_we(smc_n_we), .smc_n_wr(smc_n_wr)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted access pushes its expected per-cycle outputs
  always @(posedge hclk or posedge sys_reset)
    if (sys_reset) q.delete();
    else begin
      bit rdy;
      rdy = q.size() == 0 || (BURST && q[0].done);
      if (q.size() != 0) void'(q.pop_front());
      if (wr_req && rdy) begin
        for (int i = 0; i < int'(cfg_setup); i++) q.push_back('{1'b0, 1'b1, 4'hF});
        for (int i = 0; i <= int'(cfg_pulse); i++)
          q.push_back('{(i == int'(cfg_pulse)) && cfg_hold == 0, 1'b0, ~wr_be});
        for (int i = 0; i < int'(cfg_hold); i++) q.push_back('{i == int'(cfg_hold) - 1, 1'b1, 4'hF});
        acc_cnt++;
      end
    end

  always @(negedge hclk)
    if (chk_en) begin
      logic [7:0] e;
      e = (q.size() == 0) ? 8'h9F : {BURST && q[0].done, q[0].done, 1'b1, q[0].n_wr, q[0].n_we};
      check("cycle", {wr_ready, wr_done, busy, smc_n_wr, smc_n_we}, e);
    end

  task automatic wait_idle();
    for (int n = 0; n < 100; n++) begin
      @(negedge hclk);
      if (!busy) return;
    end
    total++; bad++;
    $display("FAIL idle_timeout: busy still 1 after 100 cycles, required 0");
  endtask

  task automatic run(input vec_t v, input logic [3:0] post_pulse, output int nbusy, output int nlow);
    int a0, n;
    a0 = acc_cnt;
    cfg_setup = v.setup; cfg_pulse = v.pulse; cfg_hold = v.hold; wr_be = v.be; wr_req = 1'b1;
    n = 0;
    do begin @(posedge hclk); #1; n++; end while (acc_cnt == a0 && n < 40);
    wr_req = 1'b0;
    cfg_setup = 4'($urandom); cfg_pulse = post_pulse; cfg_hold = 4'($urandom); wr_be = 4'($urandom);
    if (acc_cnt == a0) begin
      total++; bad++;
      $display("FAIL accept_timeout: waited %0d cycles, required acceptance", n);
    end
    nbusy = 0; nlow = 0;
    for (n = 0; n < 100; n++) begin
      @(negedge hclk);
      if (!busy) break;
      nbusy++;
      if (!smc_n_wr) nlow++;
    end
    if (n == 100) begin
      total++; bad++;
      $display("FAIL busy_timeout: busy stuck for %0d cycles, required idle", n);
    end
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    int nb, nl, last;
    tbl = '{
      '{4'd2, 4'd1, 4'd1, 4'b0101, 5, 2},
      '{4'd0, 4'd0, 4'd0, 4'hF, 1, 1},
      '{4'd0, 4'd3, 4'd0, 4'h0, 4, 4},
      '{4'hF, 4'hF, 4'hF, 4'hA, 46, 16},
      '{4'd0, 4'd2, 4'd3, 4'b1000, 6, 3},
      '{4'd3, 4'd0, 4'd0, 4'b0011, 4, 1},
      '{4'd1, 4'd1, 4'd2, 4'hC, 5, 2}
    };
    #12;
    check("reset_state", {wr_ready, wr_done, busy, smc_n_wr, smc_n_we}, 8'h9F);
    #1 sys_reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run(tbl[i], 4'($urandom), nb, nl);
      check($sformatf("vec%0d_busy", i), nb, tbl[i].exp_busy);
      check($sformatf("vec%0d_strobe", i), nl, tbl[i].exp_low);
    end
    // abort in the second STROBE cycle, then accept on the first edge after release
    cfg_setup = 4'd0; cfg_pulse = 4'd3; cfg_hold = 4'd0; wr_be = 4'hF; wr_req = 1'b1;
    @(posedge hclk); #1 wr_req = 1'b0;
    @(posedge hclk); #2;
    check("pre_reset_strobe", {smc_n_wr, smc_n_we}, 5'b00000);
    sys_reset = 1'b1;
    #1 check("reset_async", {wr_ready, wr_done, busy, smc_n_wr, smc_n_we}, 8'h9F);
    #1 sys_reset = 1'b0;
    cfg_setup = 4'd0; cfg_pulse = 4'd0; cfg_hold = 4'd0; wr_be = 4'b0101; wr_req = 1'b1;
    @(posedge hclk); #1 wr_req = 1'b0;
    check("post_reset_accept", {busy, wr_done, smc_n_wr, smc_n_we}, 7'b1101010);
    wait_idle();
    // wr_req held: strobe period shows whether accesses run back to back
    cfg_setup = 4'd1; cfg_pulse = 4'd0; cfg_hold = 4'd1; wr_be = 4'hF; wr_req = 1'b1;
    last = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge hclk);
      if (!smc_n_wr) begin
        if (last >= 0) check("strobe_period", c - last, PERIOD);
        last = c;
      end
    end
    check("strobe_seen", last >= 0, 1);
    wr_req = 1'b0;
    wait_idle();
    wait_idle();
    // cfg_pulse changes mid-access must not stretch the current strobe
    v = '{4'd0, 4'd1, 4'd0, 4'hF, 2, 2};
    run(v, 4'd7, nb, nl);
    check("pulse_change_cur", nl, 2);
    v = '{4'd0, 4'd7, 4'd0, 4'hF, 8, 8};
    run(v, 4'($urandom), nb, nl);
    check("pulse_change_next", nl, 8);
    check("pulse_change_busy", nb, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
